poly_voice_allocator: RTL and testbench

Parametrised polyphonic voice allocator for the keyboard synth path. It decodes PS/2 key events into note numbers and assigns notes to a configurable number of voices, with retrigger, oldest-voice stealing and a linear release ramp. Per-voice frequency and volume words go straight to the oscillator/mixer bank. It supersedes the fixed 8-voice keyboard block.

---
 rtl/poly_voice_allocator_pkg.sv | 57 +++++
 rtl/poly_voice_allocator_if.sv | 22 ++
 rtl/poly_voice_allocator_voice_picker.sv | 47 ++++
 rtl/poly_voice_allocator.sv | 146 ++++++++++++++
 tb/tb_poly_voice_allocator.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/poly_voice_allocator_pkg.sv
// Shared synth types and helpers: Q12.20 constants, FSM states,
// PS/2 scancode to note decoding and the Pythagorean note frequency table.
package synth_pkg;
    localparam int          FRAC_W           = 20;
    localparam logic [31:0] Q_ONE            = 32'h0010_0000;
    localparam logic [31:0] GROUND_NOTE_FREQ = 32'd55 << FRAC_W;
    localparam int          NOTE_W           = 5;

    typedef logic [NOTE_W-1:0] note_t;
    typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_APPLY} state_t;

    // Set-2 scancodes: home row plus the black keys above it, then the
    // bottom row, then digits. Extended codes (bit 8 set) never map to a note.
    function automatic int get_note_number(input logic [8:0] scancode);
        int n;
        n = -1;
        case (scancode)
            9'h01C: n = 0;   9'h01D: n = 1;   9'h01B: n = 2;   9'h024: n = 3;
            9'h023: n = 4;   9'h02B: n = 5;   9'h02C: n = 6;   9'h034: n = 7;
            9'h035: n = 8;   9'h033: n = 9;   9'h03C: n = 10;  9'h03B: n = 11;
            9'h042: n = 12;  9'h044: n = 13;  9'h04B: n = 14;  9'h04D: n = 15;
            9'h04C: n = 16;  9'h052: n = 17;  9'h01A: n = 18;  9'h022: n = 19;
            9'h021: n = 20;  9'h02A: n = 21;  9'h032: n = 22;  9'h031: n = 23;
            9'h03A: n = 24;  9'h041: n = 25;  9'h049: n = 26;  9'h04A: n = 27;
            9'h016: n = 28;  9'h01E: n = 29;  9'h026: n = 30;  9'h025: n = 31;
            default: n = -1;
        endcase
        return n;
    endfunction

    // Pythagorean ratio for the semitone, scaled by octave, truncated to Q12.20.
    function automatic logic [31:0] note_freq(input note_t idx);
        logic [63:0]  num, den, f;
        int unsigned  semi, oct;
        semi = idx % 12;
        oct  = idx / 12;
        num  = 64'd1;
        den  = 64'd1;
        case (semi)
            0:  begin num = 64'd1;   den = 64'd1;   end
            1:  begin num = 64'd256; den = 64'd243; end
            2:  begin num = 64'd9;   den = 64'd8;   end
            3:  begin num = 64'd32;  den = 64'd27;  end
            4:  begin num = 64'd81;  den = 64'd64;  end
            5:  begin num = 64'd4;   den = 64'd3;   end
            6:  begin num = 64'd729; den = 64'd512; end
            7:  begin num = 64'd3;   den = 64'd2;   end
            8:  begin num = 64'd128; den = 64'd81;  end
            9:  begin num = 64'd27;  den = 64'd16;  end
            10: begin num = 64'd16;  den = 64'd9;   end
            default: begin num = 64'd243; den = 64'd128; end
        endcase
        f = (64'(GROUND_NOTE_FREQ) * num) / den;
        f = f << oct;
        return f[31:0];
    endfunction
endpackage

// File: rtl/poly_voice_allocator_if.sv
// Key-event input and per-voice output bus of the voice allocator.
interface poly_voice_allocator_if
    import synth_pkg::*;
#(
    parameter int VOICES = 8
);
    logic [10:0]                   ps2_key;
    logic [VOICES-1:0][31:0]       frequencies;
    logic [VOICES-1:0][31:0]       voice_volumes;
    logic [VOICES-1:0][NOTE_W-1:0] voice_notes;
    logic [VOICES-1:0]             voice_held;
    logic                          event_dropped;

    modport master (
        output ps2_key,
        input  frequencies, voice_volumes, voice_notes, voice_held, event_dropped
    );
    modport slave (
        input  ps2_key,
        output frequencies, voice_volumes, voice_notes, voice_held, event_dropped
    );
endinterface

// File: rtl/poly_voice_allocator_voice_picker.sv
// Combinational voice choice for a key press: retrigger a sounding voice
// holding the same note, else the lowest free voice, else the oldest voice.
module voice_picker
    import synth_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int AGE_W  = 8,
    localparam int IDX_W = $clog2(VOICES)
) (
    input  logic [VOICES-1:0][31:0]       volumes,
    input  logic [VOICES-1:0][NOTE_W-1:0] notes,
    input  logic [VOICES-1:0][AGE_W-1:0]  ages,
    input  note_t                         note,
    output logic [IDX_W-1:0]              index,
    output logic                          valid
);
    // Single scan collecting all three candidates; the first match wins for
    // hit/free, strict '>' keeps the lowest index among equal ages.
    always_comb begin
        logic             hit_found, free_found;
        logic [IDX_W-1:0] hit_idx, free_idx, old_idx;
        logic [AGE_W-1:0] old_age;
        hit_found  = 1'b0;
        free_found = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        old_idx    = '0;
        old_age    = ages[0];
        for (int i = 0; i < VOICES; i++) begin
            if (!hit_found && notes[i] == note && volumes[i] != '0) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
            if (!free_found && volumes[i] == '0) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ages[i] > old_age) begin
                old_age = ages[i];
                old_idx = IDX_W'(i);
            end
        end
        index = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
        // Stealing always yields a voice, so a choice is always available.
        valid = 1'b1;
    end
endmodule

// File: rtl/poly_voice_allocator.sv
// Polyphonic voice allocator: PS/2 event capture into a one-entry pending
// slot, IDLE/DECODE/APPLY sequencing, and a divided linear release ramp.
module poly_voice_allocator
    import synth_pkg::*;
#(
    parameter int          VOICES       = 8,
    parameter int          NOTES        = 32,
    parameter logic [31:0] VOL_MAX      = Q_ONE,
    parameter logic [31:0] RELEASE_STEP = 32'h0000_4000,
    parameter int          RELEASE_DIV  = 4096,
    parameter int          AGE_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    poly_voice_allocator_if.slave   bus
);
    localparam int IDX_W = $clog2(VOICES);
    localparam int DIV_W = $clog2(RELEASE_DIV);

    logic                          toggle_q, pend_full, pend_pressed, dropped;
    logic [8:0]                    pend_code;
    state_t                        state, state_nxt;
    note_t                         dec_note_p1;
    logic [DIV_W-1:0]              div_cnt;
    logic [VOICES-1:0][31:0]       freq, vol;
    logic [VOICES-1:0][NOTE_W-1:0] notes;
    logic [VOICES-1:0]             held;
    logic [VOICES-1:0][AGE_W-1:0]  age;
    logic [IDX_W-1:0]              pick_idx;
    logic                          pick_valid;
    int                            dec_num;

    function automatic logic [31:0] vol_dec(input logic [31:0] v);
        return (v > RELEASE_STEP) ? v - RELEASE_STEP : '0;
    endfunction

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a == '1) ? a : a + 1'b1;
    endfunction

    wire toggle_evt = bus.ps2_key[10] != toggle_q;
    wire note_valid = (dec_num >= 0) && (dec_num < NOTES);
    wire pend_done  = (state == ST_APPLY) || (state == ST_DECODE && !note_valid);
    wire tick       = div_cnt == DIV_W'(RELEASE_DIV - 1);

    assign dec_num = get_note_number(pend_code);

    voice_picker #(.VOICES(VOICES), .AGE_W(AGE_W)) u_picker (
        .volumes (vol),
        .notes   (notes),
        .ages    (age),
        .note    (dec_note_p1),
        .index   (pick_idx),
        .valid   (pick_valid)
    );

    // p0: edge-detect the toggle strobe and fill or overflow the pending slot
    always_ff @(posedge clk) begin
        toggle_q <= bus.ps2_key[10];
        if (reset) begin
            pend_full    <= 1'b0;
            pend_pressed <= 1'b0;
            pend_code    <= '0;
            dropped      <= 1'b0;
        end else begin
            dropped <= 1'b0;
            if (pend_done) pend_full <= 1'b0;
            if (toggle_evt) begin
                if (pend_full) begin
                    dropped <= 1'b1;
                end else begin
                    pend_full    <= 1'b1;
                    pend_pressed <= bus.ps2_key[9];
                    pend_code    <= bus.ps2_key[8:0];
                end
            end
        end
    end

    // FSM state register and free-running release divider
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

    // Next state: a toggle seen in IDLE enters DECODE on the following cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pend_full || toggle_evt) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = note_valid ? ST_APPLY : ST_IDLE;
            ST_APPLY:  state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // p1: hold the decoded note for the APPLY cycle
    always_ff @(posedge clk) begin
        if (state == ST_DECODE) dec_note_p1 <= note_t'(dec_num);
    end

    // p2: voice state; APPLY assignments come last so they override the ramp
    always_ff @(posedge clk) begin
        if (reset) begin
            freq  <= '0;
            vol   <= '0;
            notes <= '0;
            held  <= '0;
            age   <= '0;
        end else begin
            if (tick) begin
                for (int i = 0; i < VOICES; i++)
                    if (!held[i] && vol[i] != '0) vol[i] <= vol_dec(vol[i]);
            end
            if (state == ST_APPLY) begin
                if (pend_pressed) begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (pick_valid && IDX_W'(i) == pick_idx) begin
                            vol[i]   <= VOL_MAX;
                            freq[i]  <= note_freq(dec_note_p1);
                            notes[i] <= dec_note_p1;
                            held[i]  <= 1'b1;
                            age[i]   <= '0;
                        end else begin
                            age[i]   <= age_inc(age[i]);
                        end
                    end
                end else begin
                    for (int i = 0; i < VOICES; i++)
                        if (held[i] && notes[i] == dec_note_p1) held[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.frequencies   = freq;
    assign bus.voice_volumes = vol;
    assign bus.voice_notes   = notes;
    assign bus.voice_held    = held;
    assign bus.event_dropped = dropped;
endmodule

// File: tb/tb_poly_voice_allocator.sv
// Directed bench for poly_voice_allocator with a fast release ramp.
module tb_poly_voice_allocator;
    import synth_pkg::*;

    localparam int V = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] sc [32] = '{
        9'h01C, 9'h01D, 9'h01B, 9'h024, 9'h023, 9'h02B, 9'h02C, 9'h034,
        9'h035, 9'h033, 9'h03C, 9'h03B, 9'h042, 9'h044, 9'h04B, 9'h04D,
        9'h04C, 9'h052, 9'h01A, 9'h022, 9'h021, 9'h02A, 9'h032, 9'h031,
        9'h03A, 9'h041, 9'h049, 9'h04A, 9'h016, 9'h01E, 9'h026, 9'h025
    };

    always #5 clk = ~clk;

    poly_voice_allocator_if #(.VOICES(V)) bus();

    poly_voice_allocator #(
        .VOICES(V), .NOTES(32), .VOL_MAX(32'h0010_0000),
        .RELEASE_STEP(32'h0004_0000), .RELEASE_DIV(4), .AGE_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic pressed, input logic [8:0] code);
        bus.ps2_key = {~bus.ps2_key[10], pressed, code};
    endtask

    task automatic play(input logic pressed, input logic [8:0] code);
        key(pressed, code);
        tick(3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] prev;
        int          steps, last_c;
        logic        held_seen;

        bus.ps2_key = '0;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < V; i++) begin
            chk($sformatf("rst_vol%0d", i), bus.voice_volumes[i], 0);
            chk($sformatf("rst_freq%0d", i), bus.frequencies[i], 0);
        end
        chk("rst_held", bus.voice_held, 0);
        chk("rst_notes", bus.voice_notes, 0);
        chk("rst_drop", bus.event_dropped, 0);

        // Single press: three-cycle latency
        key(1'b1, sc[0]);
        tick(2);
        chk("lat_vol_c2", bus.voice_volumes[0], 0);
        tick(1);
        chk("a_vol", bus.voice_volumes[0], 32'h0010_0000);
        chk("a_freq", bus.frequencies[0], 32'd57671680);
        chk("a_held", bus.voice_held, 8'h01);
        chk("a_note", bus.voice_notes[0], 0);

        // Retrigger reuses the same voice
        do_reset();
        play(1'b1, sc[3]);
        play(1'b1, sc[3]);
        chk("retrig_held", bus.voice_held, 8'h01);
        chk("retrig_vol1", bus.voice_volumes[1], 0);
        chk("retrig_note0", bus.voice_notes[0], 3);
        chk("retrig_vol0", bus.voice_volumes[0], 32'h0010_0000);

        // Fill all voices, then steal the oldest twice
        do_reset();
        for (int i = 0; i < 8; i++) play(1'b1, sc[i]);
        chk("fill_held", bus.voice_held, 8'hFF);
        chk("fill_note7", bus.voice_notes[7], 7);
        chk("fill_freq7", bus.frequencies[7], 32'd86507520);
        play(1'b1, sc[8]);
        chk("steal_note0", bus.voice_notes[0], 8);
        chk("steal_freq0", bus.frequencies[0], 32'd91135494);
        chk("steal_note1", bus.voice_notes[1], 1);
        play(1'b1, sc[9]);
        chk("steal2_note1", bus.voice_notes[1], 9);
        chk("steal2_note2", bus.voice_notes[2], 2);
        chk("steal2_note0", bus.voice_notes[0], 8);

        // Release ramp: four ticks of 0x40000 down to zero, four cycles apart
        do_reset();
        play(1'b1, sc[5]);
        key(1'b0, sc[5]);
        tick(3);
        chk("rel_held", bus.voice_held, 0);
        chk("rel_vol_start", bus.voice_volumes[0], 32'h0010_0000);
        prev      = bus.voice_volumes[0];
        steps     = 0;
        last_c    = -1;
        held_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            if (bus.voice_held != 0) held_seen = 1'b1;
            if (bus.voice_volumes[0] != prev) begin
                chk($sformatf("ramp_step%0d", steps), bus.voice_volumes[0], prev - 32'h0004_0000);
                if (last_c >= 0) chk($sformatf("ramp_gap%0d", steps), c - last_c, 4);
                last_c = c;
                steps++;
                prev = bus.voice_volumes[0];
            end
        end
        chk("ramp_steps", steps, 4);
        chk("ramp_final", bus.voice_volumes[0], 0);
        chk("ramp_held", held_seen, 0);
        chk("ramp_note_kept", bus.voice_notes[0], 5);
        chk("ramp_freq_kept", bus.frequencies[0], 32'd76895573);

        // Second toggle one cycle later is dropped
        do_reset();
        key(1'b1, sc[2]);
        tick(1);
        chk("drop_pre", bus.event_dropped, 0);
        key(1'b1, sc[4]);
        tick(1);
        chk("drop_pulse", bus.event_dropped, 1);
        tick(1);
        chk("drop_clear", bus.event_dropped, 0);
        chk("drop_note0", bus.voice_notes[0], 2);
        tick(3);
        chk("drop_held", bus.voice_held, 8'h01);
        chk("drop_vol1", bus.voice_volumes[1], 0);

        // Unmapped scancodes change nothing
        do_reset();
        play(1'b1, sc[0]);
        key(1'b1, 9'h0FF);
        tick(5);
        key(1'b1, 9'h11C);
        tick(5);
        key(1'b0, 9'h0FF);
        tick(5);
        chk("unmap_held", bus.voice_held, 8'h01);
        chk("unmap_vol1", bus.voice_volumes[1], 0);
        chk("unmap_note0", bus.voice_notes[0], 0);

        // Reset during APPLY clears everything on the next cycle
        do_reset();
        play(1'b1, sc[0]);
        key(1'b1, sc[1]);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rapply_vol0", bus.voice_volumes[0], 0);
        chk("rapply_vol1", bus.voice_volumes[1], 0);
        chk("rapply_freq0", bus.frequencies[0], 0);
        chk("rapply_held", bus.voice_held, 0);
        chk("rapply_notes", bus.voice_notes, 0);
        reset = 1'b0;
        tick(4);
        chk("rapply_no_event", bus.voice_held, 0);
        chk("rapply_no_vol", bus.voice_volumes[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
